serial_tx: RTL and testbench



---
 rtl/serial_tx_pkg.sv | 18 +
 rtl/serial_tx_bit_timer.sv | 36 +++
 rtl/serial_tx.sv | 116 +++++++++++
 tb/tb_serial_tx.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg
// Definitions shared by the serial link transmitter and its matching receiver:
//   state_t     - frame FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3)
//   LINE_IDLE   - level the serial line rests at between frames
//   LINE_START  - level of the start bit
package serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer
// Divides the clock into bit periods of CLKS_PER_BIT cycles.
// Ports:
//   clk     - clock, all state changes on posedge
//   r       - asynchronous active-high reset
//   clear   - holds the tick counter at 0 (used while the line is idle so
//             the first bit period starts cleanly at the accept edge)
//   bit_end - high in the last cycle of each bit period
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic r,
    input  logic clear,
    output logic bit_end
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] tick_cnt;

    // With CLKS_PER_BIT=1 the counter is stuck at 0 and every cycle ends a bit.
    assign bit_end = (tick_cnt == LAST_TICK);

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            tick_cnt <= '0;
        end else if (clear || bit_end) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx
// Parallel-in, serial-out transmitter. A word accepted on the valid/ready
// handshake is sent as: start bit (0), DATA_W data bits LSB first, stop bit (1),
// each bit held for CLKS_PER_BIT clocks. The line idles high.
// Ports:
//   clk   - clock, all state changes on posedge
//   r     - asynchronous active-high reset (aborts any frame, line goes high)
//   data  - word to send, sampled only at accept
//   valid - producer has a word on data
//   ready - block can accept a word (IDLE only)
//   tx    - serial line out, registered
//   busy  - frame in progress
//   done  - one-cycle pulse in the first IDLE cycle after a stop bit
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              r,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [BW-1:0]     bit_cnt;
    logic              bit_end;
    logic              timer_clear;

    // Keep the tick counter parked at 0 while idle so the start bit gets a
    // full period beginning right after the accept edge.
    assign timer_clear = (state == IDLE);
    assign shift_next  = shift_reg >> 1;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (clk),
        .r      (r),
        .clear  (timer_clear),
        .bit_end(bit_end)
    );

    // tx, ready, busy and done are all registered and updated on the same
    // edge as the state change, so they line up exactly with the state.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx        <= LINE_IDLE;
            ready     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid) begin
                        shift_reg <= data;
                        bit_cnt   <= '0;
                        state     <= START;
                        tx        <= LINE_START;
                        ready     <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        tx      <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_reg <= shift_next;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                            tx    <= LINE_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift_next[0];
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        tx    <= LINE_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= LINE_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Testbench for serial_tx: one instance at DATA_W=8/CLKS_PER_BIT=4 and one at
// DATA_W=8/CLKS_PER_BIT=1. Expected per-cycle {tx,busy,ready,done} values are
// queued when a word is offered and popped one per clock; an empty queue means
// the line must be idle.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       r = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       valid0 = 1'b0, valid1 = 1'b0;
    logic       ready0, tx0, busy0, done0;
    logic       ready1, tx1, busy1, done1;

    int checks = 0;
    int failures = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];

    localparam logic [3:0] EXP_IDLE = 4'b1010;  // tx=1 busy=0 ready=1 done=0
    localparam logic [3:0] EXP_DONE = 4'b1011;  // first IDLE cycle after stop

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
        .clk(clk), .r(r), .data(data0), .valid(valid0),
        .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .r(r), .data(data1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s {tx,busy,ready,done} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input int which, input logic [3:0] e);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    // Model of one frame: start, 8 data bits LSB first, stop, then the done cycle.
    task automatic push_frame(input int which, input logic [7:0] d, input int cpb);
        logic bitv;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      bitv = 1'b0;
            else if (b == 9) bitv = 1'b1;
            else             bitv = d[b-1];
            for (int k = 0; k < cpb; k++) push(which, {bitv, 1'b1, 1'b0, 1'b0});
        end
        push(which, EXP_DONE);
    endtask

    task automatic step(input string tag);
        logic [3:0] e0, e1;
        @(posedge clk);
        #1;
        e0 = (q0.size() > 0) ? q0.pop_front() : EXP_IDLE;
        e1 = (q1.size() > 0) ? q1.pop_front() : EXP_IDLE;
        check({tag, "/u0"}, {tx0, busy0, ready0, done0}, e0);
        check({tag, "/u1"}, {tx1, busy1, ready1, done1}, e1);
        $display("t=%0t %s u0 tx=%b busy=%b ready=%b done=%b | u1 tx=%b busy=%b ready=%b done=%b",
                 $time, tag, tx0, busy0, ready0, done0, tx1, busy1, ready1, done1);
    endtask

    initial begin
        // Reset with the clock stopped: must take effect immediately.
        #3 r = 1'b1;
        #1;
        check("async_reset/u0", {tx0, busy0, ready0, done0}, EXP_IDLE);
        check("async_reset/u1", {tx1, busy1, ready1, done1}, EXP_IDLE);
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        #1 r = 1'b0;
        repeat (20) step("idle_after_reset");

        // Single frame 0xA5, valid pulsed for one cycle.
        data0 = 8'hA5; valid0 = 1'b1;
        push_frame(0, 8'hA5, 4);
        step("single_a5");
        valid0 = 1'b0;
        repeat (40) step("single_a5");
        repeat (2) step("gap");

        // Back-to-back 0x00 then 0xFF with valid held.
        data0 = 8'h00; valid0 = 1'b1;
        push_frame(0, 8'h00, 4);
        push_frame(0, 8'hFF, 4);
        step("b2b_00");
        data0 = 8'hFF;
        repeat (40) step("b2b_00");
        step("b2b_ff");
        valid0 = 1'b0;
        repeat (40) step("b2b_ff");
        repeat (2) step("gap");

        // Changes on data/valid during a frame are ignored.
        data0 = 8'hA5; valid0 = 1'b1;
        push_frame(0, 8'hA5, 4);
        step("ignore_busy");
        valid0 = 1'b0; data0 = 8'h3C;
        repeat (10) step("ignore_busy");
        valid0 = 1'b1;
        repeat (10) step("ignore_busy");
        valid0 = 1'b0;
        repeat (20) step("ignore_busy");
        repeat (3) step("no_extra_done");

        // Reset in cycle 20 of a 0xA5 frame, then a clean 0x5A frame.
        data0 = 8'hA5; valid0 = 1'b1;
        push_frame(0, 8'hA5, 4);
        step("abort_a5");
        valid0 = 1'b0;
        repeat (19) step("abort_a5");
        #1 r = 1'b1;
        #1;
        check("mid_frame_reset/u0", {tx0, busy0, ready0, done0}, EXP_IDLE);
        q0.delete();
        step("in_reset");
        r = 1'b0;
        repeat (5) step("after_abort");
        data0 = 8'h5A; valid0 = 1'b1;
        push_frame(0, 8'h5A, 4);
        step("frame_5a");
        valid0 = 1'b0;
        repeat (40) step("frame_5a");
        repeat (2) step("gap");

        // CLKS_PER_BIT=1 instance, 0x81.
        data1 = 8'h81; valid1 = 1'b1;
        push_frame(1, 8'h81, 1);
        step("cpb1_81");
        valid1 = 1'b0;
        repeat (10) step("cpb1_81");
        repeat (2) step("gap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
